alu_arbiter: RTL and testbench

Shares the single 64-bit ALU between NREQ requesters (e.g. execute stage, address generation, multi-cycle mul/div sequencer). Round-robin arbitration with valid/ready handshakes on both request and response sides; operands are registered before the ALU and the result is registered after it. At most one operation is in flight. The block drives the ALU's porta/portb/ALUOp inputs and consumes aluout/zero.

---
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 64-bit ALU between NREQ requesters.
// Operands are registered in front of the ALU and the result is registered
// behind it, so an accepted op is answered two cycles later. Only one op is
// ever in flight; the next accept can coincide with the response handshake.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 64,
  parameter int OPW  = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_porta,
  input  logic [NREQ*DW-1:0]  req_portb,
  input  logic [NREQ*OPW-1:0] req_aluop,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [DW-1:0]       resp_data,
  output logic                resp_zero,
  output logic [DW-1:0]       alu_porta,
  output logic [DW-1:0]       alu_portb,
  output logic [OPW-1:0]      alu_op,
  input  logic [DW-1:0]       alu_out,
  input  logic                alu_zero
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [DW-1:0]  porta_q, porta_d;
  logic [DW-1:0]  portb_q, portb_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  resp_data_q, resp_data_d;
  logic           resp_zero_q, resp_zero_d;

  logic           grant_found;
  logic [PW-1:0]  grant_idx;
  logic [PW:0]    scan_sum;
  logic [DW-1:0]  grant_porta;
  logic [DW-1:0]  grant_portb;
  logic [OPW-1:0] grant_op;
  logic           owner_ready;
  logic           accepting;
  logic           accept_fire;

  // Round-robin search: first valid requester starting at ptr, wrapping mod NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      if (!grant_found && req_valid[scan_sum[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[PW-1:0];
      end
    end
  end

  // Select the granted requester's operands and op code.
  always_comb begin
    grant_porta = '0;
    grant_portb = '0;
    grant_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        grant_porta = req_porta[i*DW +: DW];
        grant_portb = req_portb[i*DW +: DW];
        grant_op    = req_aluop[i*OPW +: OPW];
      end
    end
  end

  // Response side: one-hot valid for the owner, and the owner's ready bit only.
  always_comb begin
    resp_valid  = '0;
    owner_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = (state_q == RESP) && (owner_q == PW'(i));
      if (owner_q == PW'(i)) begin
        owner_ready = resp_ready[i];
      end
    end
  end

  // Accept when idle, or when the pending response is being consumed this cycle.
  always_comb begin
    accepting   = (state_q == IDLE) || ((state_q == RESP) && owner_ready);
    accept_fire = accepting && grant_found;
    req_ready   = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept_fire && (grant_idx == PW'(i));
    end
  end

  // Next-state logic for the FSM, op registers, pointer and result registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    porta_d     = porta_q;
    portb_d     = portb_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;

    case (state_q)
      IDLE: begin
        if (accept_fire) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = alu_out;
        resp_zero_d = alu_zero;
        state_d     = RESP;
      end
      RESP: begin
        if (accepting) begin
          state_d = accept_fire ? EXEC : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_fire) begin
      porta_d = grant_porta;
      portb_d = grant_portb;
      op_d    = grant_op;
      owner_d = grant_idx;
      if (grant_idx == PW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PW'(1);
      end
    end
  end

  // State and datapath registers; reset drops any op in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      porta_q     <= '0;
      portb_q     <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      porta_q     <= porta_d;
      portb_q     <= portb_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
    end
  end

  assign alu_porta = porta_q;
  assign alu_portb = portb_q;
  assign alu_op    = op_q;
  assign resp_data = resp_data_q;
  assign resp_zero = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance covers reset, single
// op, zero flag, fairness, backpressure and reset mid-op; a 4-requester
// instance covers pointer wrap. A tiny ALU (ADD/SUB) sits behind each instance.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  logic clk;
  logic rstN;

  logic [1:0]   valid2, ready2, respValid2, respReady2;
  logic [127:0] portA2, portB2;
  logic [7:0]   aluOps2;
  logic [63:0]  respData2, aluA2, aluB2, aluOut2;
  logic [3:0]   aluOp2;
  logic         respZero2, aluZero2;

  logic [3:0]   valid4, ready4, respValid4, respReady4;
  logic [255:0] portA4, portB4;
  logic [15:0]  aluOps4;
  logic [63:0]  respData4, aluA4, aluB4, aluOut4;
  logic [3:0]   aluOp4;
  logic         respZero4, aluZero4;

  int totalChecks;
  int badChecks;

  alu_arbiter #(.NREQ(2), .DW(64), .OPW(4)) dut2 (
    .CLK(clk), .nRST(rstN),
    .req_valid(valid2), .req_ready(ready2),
    .req_porta(portA2), .req_portb(portB2), .req_aluop(aluOps2),
    .resp_valid(respValid2), .resp_ready(respReady2),
    .resp_data(respData2), .resp_zero(respZero2),
    .alu_porta(aluA2), .alu_portb(aluB2), .alu_op(aluOp2),
    .alu_out(aluOut2), .alu_zero(aluZero2)
  );

  alu_arbiter #(.NREQ(4), .DW(64), .OPW(4)) dut4 (
    .CLK(clk), .nRST(rstN),
    .req_valid(valid4), .req_ready(ready4),
    .req_porta(portA4), .req_portb(portB4), .req_aluop(aluOps4),
    .resp_valid(respValid4), .resp_ready(respReady4),
    .resp_data(respData4), .resp_zero(respZero4),
    .alu_porta(aluA4), .alu_portb(aluB4), .alu_op(aluOp4),
    .alu_out(aluOut4), .alu_zero(aluZero4)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Minimal ALU models: ADD and SUB, anything else yields zero.
  always_comb begin
    aluOut2 = '0;
    if (aluOp2 == OP_ADD) aluOut2 = aluA2 + aluB2;
    else if (aluOp2 == OP_SUB) aluOut2 = aluA2 - aluB2;
    aluZero2 = (aluOut2 == 64'd0);
  end

  always_comb begin
    aluOut4 = '0;
    if (aluOp4 == OP_ADD) aluOut4 = aluA4 + aluB4;
    else if (aluOp4 == OP_SUB) aluOut4 = aluA4 - aluB4;
    aluZero4 = (aluOut4 == 64'd0);
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the handshake inputs of the 2-requester instance and let them settle.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] respReady);
    valid2     = valid;
    respReady2 = respReady;
    #1;
  endtask

  task automatic setOp2(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op);
    portA2[idx*64 +: 64] = a;
    portB2[idx*64 +: 64] = b;
    aluOps2[idx*4 +: 4]  = op;
  endtask

  task automatic setOp4(input int idx, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op);
    portA4[idx*64 +: 64] = a;
    portB4[idx*64 +: 64] = b;
    aluOps4[idx*4 +: 4]  = op;
  endtask

  // Advance one clock edge and move away from it before touching anything.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rstN        = 1'b0;
    valid2 = '0; respReady2 = '0; portA2 = '0; portB2 = '0; aluOps2 = '0;
    valid4 = '0; respReady4 = '0; portA4 = '0; portB4 = '0; aluOps4 = '0;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_req_ready", 64'(ready2), 64'h0);
    checkOutput("rst_resp_valid", 64'(respValid2), 64'h0);
    checkOutput("rst_resp_data", respData2, 64'h0);
    checkOutput("rst_alu_porta", aluA2, 64'h0);
    checkOutput("rst_ptr4", 64'(dut4.ptr_q), 64'h0);
    rstN = 1'b1;
    stepCycle();

    // Single op: 5 + 7
    setOp2(0, 64'd5, 64'd7, OP_ADD);
    applyStimulus(2'b01, 2'b11);
    checkOutput("single_req_ready", 64'(ready2), 64'h1);
    stepCycle();
    applyStimulus(2'b00, 2'b11);
    checkOutput("single_exec_resp_valid", 64'(respValid2), 64'h0);
    checkOutput("single_alu_porta", aluA2, 64'd5);
    checkOutput("single_alu_portb", aluB2, 64'd7);
    stepCycle();
    checkOutput("single_resp_valid", 64'(respValid2), 64'h1);
    checkOutput("single_resp_data", respData2, 64'd12);
    checkOutput("single_resp_zero", 64'(respZero2), 64'h0);
    stepCycle();
    checkOutput("single_idle_resp_valid", 64'(respValid2), 64'h0);

    // Zero flag: 0x1234 - 0x1234 from requester 1
    setOp2(1, 64'h1234, 64'h1234, OP_SUB);
    applyStimulus(2'b10, 2'b11);
    checkOutput("zero_req_ready", 64'(ready2), 64'h2);
    stepCycle();
    applyStimulus(2'b00, 2'b11);
    stepCycle();
    checkOutput("zero_resp_valid", 64'(respValid2), 64'h2);
    checkOutput("zero_resp_data", respData2, 64'h0);
    checkOutput("zero_resp_zero", 64'(respZero2), 64'h1);
    stepCycle();

    // Fairness: both valid, grants alternate every other cycle
    setOp2(0, 64'd1, 64'd2, OP_ADD);
    setOp2(1, 64'd10, 64'd20, OP_ADD);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, 2'b11);
      if (c % 2 == 1) begin
        checkOutput($sformatf("fair_ready_c%0d", c), 64'(ready2), 64'h0);
      end else begin
        checkOutput($sformatf("fair_ready_c%0d", c), 64'(ready2),
                    ((c / 2) % 2 == 0) ? 64'h1 : 64'h2);
      end
      if (c == 2 || c == 6) begin
        checkOutput($sformatf("fair_resp_valid_c%0d", c), 64'(respValid2), 64'h1);
        checkOutput($sformatf("fair_resp_data_c%0d", c), respData2, 64'd3);
      end else if (c == 4) begin
        checkOutput("fair_resp_valid_c4", 64'(respValid2), 64'h2);
        checkOutput("fair_resp_data_c4", respData2, 64'd30);
      end
      stepCycle();
    end
    applyStimulus(2'b00, 2'b11);
    checkOutput("fair_last_resp_valid", 64'(respValid2), 64'h2);
    checkOutput("fair_last_resp_data", respData2, 64'd30);
    checkOutput("fair_last_ready", 64'(ready2), 64'h0);
    stepCycle();

    // Backpressure: owner 0 stalls with requester 1 pending
    setOp2(0, 64'd100, 64'd23, OP_ADD);
    setOp2(1, 64'd7, 64'd3, OP_SUB);
    applyStimulus(2'b01, 2'b00);
    checkOutput("bp_first_ready", 64'(ready2), 64'h1);
    stepCycle();
    applyStimulus(2'b10, 2'b00);
    checkOutput("bp_exec_ready", 64'(ready2), 64'h0);
    stepCycle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b10, 2'b10);
      checkOutput($sformatf("bp_hold_valid_c%0d", c), 64'(respValid2), 64'h1);
      checkOutput($sformatf("bp_hold_data_c%0d", c), respData2, 64'd123);
      checkOutput($sformatf("bp_hold_ready_c%0d", c), 64'(ready2), 64'h0);
      stepCycle();
    end
    applyStimulus(2'b10, 2'b01);
    checkOutput("bp_release_ready", 64'(ready2), 64'h2);
    stepCycle();
    applyStimulus(2'b00, 2'b11);
    stepCycle();
    checkOutput("bp_second_resp_valid", 64'(respValid2), 64'h2);
    checkOutput("bp_second_resp_data", respData2, 64'd4);
    checkOutput("bp_second_resp_zero", 64'(respZero2), 64'h0);
    stepCycle();

    // Reset while an op is executing
    setOp2(0, 64'd1, 64'd1, OP_ADD);
    applyStimulus(2'b01, 2'b11);
    stepCycle();
    applyStimulus(2'b00, 2'b11);
    checkOutput("midrst_exec_porta", aluA2, 64'd1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_resp_valid", 64'(respValid2), 64'h0);
    checkOutput("midrst_req_ready", 64'(ready2), 64'h0);
    checkOutput("midrst_resp_data", respData2, 64'h0);
    checkOutput("midrst_alu_porta", aluA2, 64'h0);
    stepCycle();
    checkOutput("midrst_still_no_resp", 64'(respValid2), 64'h0);
    rstN = 1'b1;
    setOp2(1, 64'd9, 64'd6, OP_ADD);
    applyStimulus(2'b10, 2'b11);
    checkOutput("postrst_req_ready", 64'(ready2), 64'h2);
    stepCycle();
    applyStimulus(2'b00, 2'b11);
    checkOutput("postrst_exec_no_resp", 64'(respValid2), 64'h0);
    stepCycle();
    checkOutput("postrst_resp_valid", 64'(respValid2), 64'h2);
    checkOutput("postrst_resp_data", respData2, 64'd15);
    stepCycle();

    // Pointer wrap on the 4-requester instance: ptr 3 -> 0 -> 1
    setOp4(2, 64'd2, 64'd2, OP_ADD);
    setOp4(3, 64'd3, 64'd3, OP_ADD);
    setOp4(0, 64'd5, 64'd5, OP_ADD);
    respReady4 = 4'b1111;
    valid4     = 4'b0100;
    #1;
    checkOutput("wrap_grant2", 64'(ready4), 64'h4);
    stepCycle();
    valid4 = 4'b0000;
    #1;
    checkOutput("wrap_ptr_after2", 64'(dut4.ptr_q), 64'd3);
    stepCycle();
    checkOutput("wrap_resp2_valid", 64'(respValid4), 64'h4);
    checkOutput("wrap_resp2_data", respData4, 64'd4);
    stepCycle();
    valid4 = 4'b1001;
    #1;
    checkOutput("wrap_grant3", 64'(ready4), 64'h8);
    stepCycle();
    valid4 = 4'b0001;
    #1;
    checkOutput("wrap_ptr_after3", 64'(dut4.ptr_q), 64'd0);
    stepCycle();
    checkOutput("wrap_resp3_valid", 64'(respValid4), 64'h8);
    checkOutput("wrap_resp3_data", respData4, 64'd6);
    checkOutput("wrap_grant0", 64'(ready4), 64'h1);
    stepCycle();
    valid4 = 4'b0000;
    #1;
    checkOutput("wrap_ptr_after0", 64'(dut4.ptr_q), 64'd1);
    stepCycle();
    checkOutput("wrap_resp0_valid", 64'(respValid4), 64'h1);
    checkOutput("wrap_resp0_data", respData4, 64'd10);
    stepCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
